mpu_matrix_loader: RTL and testbench
====================================

// Module: mpu_matrix_loader
// PURPOSE
//  Upstream feeder for the MPU elementwise operators (opposite, add, ...).
//  Accepts a serial stream of 8-bit matrix elements over a valid/ready handshake.
//  Assembles them into one flattened DIMxDIM matrix register.
//  Presents the complete matrix to the MPU operator through an output valid/ready handshake.
// PARAMETERS
//  ELEM_W  8  element width in bits
//  DIM     5  matrix side; N = DIM*DIM elements (25)
// PORTS
//  clock      in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-high; clears all state
//  clear      in   1             synchronous abort: drop partial/held matrix, clear frame_err
//  in_data    in   ELEM_W        element value
//  in_valid   in   1             in_data valid
//  in_last    in   1             marks the final element of a matrix frame
//  in_ready   out  1             loader can accept an element this cycle
//  matrix     out  ELEM_W*N      flattened matrix; element k at [ELEM_W*k +: ELEM_W]
//  out_valid  out  1             matrix complete and stable
//  out_ready  in   1             MPU operator consumes matrix
//  elem_count out  5             elements accepted in current frame (0..N-1)
//  frame_err  out  1             sticky framing error flag
// BEHAVIOUR
//  - Element order: k-th accepted element (k=0..N-1) goes to index k = row + DIM*col,
//    i.e. bits [8*(row+5*col) +: 8]; matrix ordering matches the MPU operators.
//  - FSM states: LOAD, HOLD. Reset/clear -> LOAD.
//  - in_ready = (state==LOAD), combinational from state; out_valid = (state==HOLD), registered.
//  - Reset values: state LOAD, elem_count 0, matrix all 0, out_valid 0, frame_err 0.
//  - Accept: in_valid && in_ready at rising edge -> write in_data to slot elem_count; count+1.
//  - Element N-1 accepted in cycle T:
//    * out_valid=1 from T+1; elem_count -> 0; state HOLD.
//    * If in_last was 0 on that element, still complete; set frame_err.
//  - in_last on element k<N-1 (early last): element discarded; partial frame dropped.
//    * elem_count -> 0; matrix slots left as-is (not presented).
//    * frame_err set; stay LOAD.
//  - HOLD: matrix frozen, in_ready=0.
//    * out_valid && out_ready at edge T -> LOAD at T+1 (out_valid 0, in_ready 1).
//    * No same-cycle reload; minimum N+1 cycles per matrix.
//  - out_valid, once high, stays high with matrix unchanged until consumed, clear, or reset.
//  - clear has priority over every handshake in the same cycle:
//    * the element offered in that cycle is dropped;
//    * state LOAD, count 0, matrix zeroed, out_valid 0, frame_err 0.
//  - reset mid-frame or mid-HOLD: immediate return to reset values; no partial output.
//  - frame_err is sticky; cleared only by reset or clear.
//  - No arithmetic on data; elements stored bit-exact (signedness interpreted downstream).
// TESTING
//  1. Stream 1..25, valid every cycle, last on 25th, out_ready=1:
//     -> out_valid 1 cycle after 25th; matrix[8*(row+5*col)+:8] = 1+row+5*col; frame_err=0.
//  2. Same stream, out_ready=0 for 10 cycles:
//     -> out_valid held, matrix stable, in_ready=0; transfer on first out_ready; in_ready=1 next cycle.
//  3. Random in_valid gaps (~50%):
//     -> identical matrix to test 1; elem_count tracks accepts only.
//  4. in_last on 7th element:
//     -> no out_valid, frame_err=1, elem_count=0; next clean 25-element frame loads correctly with frame_err still 1.
//  5. 25 elements with no in_last:
//     -> matrix presented, frame_err=1.
//  6. Control aborts:
//     -> assert clear at element 12: count 0, matrix 0, frame_err 0, element dropped.
//     -> assert reset during HOLD: out_valid 0 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/mpu_matrix_loader.sv
// rtl/mpu_matrix_loader.sv - serial element stream to flattened DIMxDIM matrix loader
//
// Purpose: collects ELEM_W-bit elements one per accepted handshake into a
// flattened DIM*DIM matrix register, then holds the complete matrix for the
// MPU operator until it is consumed.
//
// Ports:
//   i_clock       rising-edge clock
//   i_reset       asynchronous active-high reset
//   i_clear       synchronous abort (drops frame, zeroes matrix, clears o_frame_err)
//   i_in_data     element value
//   i_in_valid    element valid
//   i_in_last     final element of a frame
//   o_in_ready    loader accepts an element this cycle
//   o_matrix      flattened matrix, element k at [ELEM_W*k +: ELEM_W]
//   o_out_valid   matrix complete and stable
//   i_out_ready   MPU operator consumes the matrix
//   o_elem_count  elements accepted in the current frame
//   o_frame_err   sticky framing error
module mpu_matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_clear,
  input  logic [ELEM_W-1:0]               i_in_data,
  input  logic                            i_in_valid,
  input  logic                            i_in_last,
  output logic                            o_in_ready,
  output logic [ELEM_W*DIM*DIM-1:0]       o_matrix,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [$clog2(DIM*DIM)-1:0]      o_elem_count,
  output logic                            o_frame_err
);

  localparam int N     = DIM * DIM;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic [ELEM_W*N-1:0]   r_matrix;
  logic                  r_frame_err;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last_slot;
  logic                  w_early_last;
  logic                  w_missing_last;

  // clear wins over any handshake offered in the same cycle
  assign w_accept       = i_in_valid && w_in_ready && !i_clear;
  assign w_last_slot    = (r_count == LAST_IDX);
  // in_last before the final slot aborts the frame; the element itself is not stored
  assign w_early_last   = w_accept && i_in_last && !w_last_slot;
  // a full frame without in_last is still presented, but flagged
  assign w_missing_last = w_accept && w_last_slot && !i_in_last;

  // state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_accept && w_last_slot) w_state_next = S_HOLD;
        S_HOLD:  if (i_out_ready)             w_state_next = S_LOAD;
        default: w_state_next = S_LOAD;
      endcase
    end
  end

  // outputs decoded from the state flop, so o_out_valid is glitch-free
  always_comb begin
    w_in_ready  = (r_state == S_LOAD);
    o_out_valid = (r_state == S_HOLD);
  end

  assign o_in_ready = w_in_ready;

  // element counter: wraps to 0 on a completed or aborted frame
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (w_last_slot || w_early_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // matrix storage: accept number k lands in slot k (k = row + DIM*col)
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_matrix <= '0;
    end else if (i_clear) begin
      r_matrix <= '0;
    end else if (w_accept && !w_early_last) begin
      for (int k = 0; k < N; k++) begin
        if (r_count == CNT_W'(k)) begin
          r_matrix[k*ELEM_W +: ELEM_W] <= i_in_data;
        end
      end
    end
  end

  // sticky framing error
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_frame_err <= 1'b0;
    end else if (i_clear) begin
      r_frame_err <= 1'b0;
    end else if (w_early_last || w_missing_last) begin
      r_frame_err <= 1'b1;
    end
  end

  assign o_matrix     = r_matrix;
  assign o_elem_count = r_count;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// tb/tb_mpu_matrix_loader.sv - scoreboard testbench for mpu_matrix_loader
module tb_mpu_matrix_loader;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N      = DIM * DIM;
  localparam int MW     = ELEM_W * N;

  logic              clk;
  logic              i_reset;
  logic              i_clear;
  logic [ELEM_W-1:0] i_in_data;
  logic              i_in_valid;
  logic              i_in_last;
  logic              o_in_ready;
  logic [MW-1:0]     o_matrix;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [4:0]        o_elem_count;
  logic              o_frame_err;

  mpu_matrix_loader #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .i_in_last    (i_in_last),
    .o_in_ready   (o_in_ready),
    .o_matrix     (o_matrix),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_elem_count (o_elem_count),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [ELEM_W-1:0] frame_q[$];
  logic              m_err;
  logic [MW-1:0]     exp_mat_q[$];
  logic              exp_err_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // frame-level model: a matrix is simply the N accepted elements in arrival order,
  // element at (row,col) being accept number row + DIM*col
  task automatic model_accept(input logic [ELEM_W-1:0] d, input logic last);
    logic [MW-1:0] mat;
    if (last && frame_q.size() < N - 1) begin
      frame_q.delete();
      m_err = 1'b1;
    end else begin
      frame_q.push_back(d);
      if (frame_q.size() == N) begin
        if (!last) m_err = 1'b1;
        mat = '0;
        for (int col = 0; col < DIM; col++)
          for (int row = 0; row < DIM; row++)
            mat[ELEM_W*(row + DIM*col) +: ELEM_W] = frame_q[row + DIM*col];
        exp_mat_q.push_back(mat);
        exp_err_q.push_back(m_err);
        frame_q.delete();
      end
    end
    check("elem_count", 256'(o_elem_count), 256'(frame_q.size()));
  endtask

  // offer one element after random idle cycles; returns after it is accepted
  task automatic send(input logic [ELEM_W-1:0] d, input logic last, input int gap_pct);
    int t;
    i_in_valid = 1'b0;
    while ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
    end
    i_in_data  = d;
    i_in_last  = last;
    i_in_valid = 1'b1;
    t = 0;
    while (!o_in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!o_in_ready) begin
      check("in_ready_timeout", 256'(0), 256'(1));
      i_in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      model_accept(d, last);
    end
  endtask

  task automatic send_frame(input int base, input logic with_last, input int gap_pct, input logic rnd);
    for (int k = 0; k < N; k++)
      send(rnd ? ELEM_W'($urandom) : ELEM_W'(base + k), with_last && (k == N - 1), gap_pct);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    frame_q.delete();
    m_err = 1'b0;
    exp_mat_q.delete();
    exp_err_q.delete();
    check("clear_count",  256'(o_elem_count), 256'(0));
    check("clear_matrix", 256'(o_matrix),     256'(0));
    check("clear_err",    256'(o_frame_err),  256'(0));
    check("clear_valid",  256'(o_out_valid),  256'(0));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_mat_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 256'(exp_mat_q.size()), 256'(0));
  endtask

  // monitor: every cycle the matrix is presented it must equal the oldest expectation
  always @(negedge clk) begin
    if (!i_reset && o_out_valid) begin
      if (exp_mat_q.size() == 0) begin
        check("unexpected_out_valid", 256'(1), 256'(0));
      end else begin
        check("matrix",        256'(o_matrix),    256'(exp_mat_q[0]));
        check("frame_err_out", 256'(o_frame_err), 256'(exp_err_q[0]));
        check("in_ready_hold", 256'(o_in_ready),  256'(0));
        if (i_out_ready) begin
          void'(exp_mat_q.pop_front());
          void'(exp_err_q.pop_front());
        end
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_clear = 1'b0; i_in_data = '0; i_in_valid = 1'b0;
    i_in_last = 1'b0; i_out_ready = 1'b1; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  256'(o_out_valid),  256'(0));
    check("rst_ready",  256'(o_in_ready),   256'(1));
    check("rst_count",  256'(o_elem_count), 256'(0));
    check("rst_matrix", 256'(o_matrix),     256'(0));
    check("rst_err",    256'(o_frame_err),  256'(0));
    i_reset = 1'b0;
    @(posedge clk); #1;

    // 1: elements 1..25 back to back, consumed immediately
    send_frame(1, 1'b1, 0, 1'b0);
    check("t1_valid_next_cycle", 256'(o_out_valid), 256'(1));
    drain();
    check("t1_err", 256'(o_frame_err), 256'(0));

    // 2: downstream stalls for 10 cycles
    i_out_ready = 1'b0;
    send_frame(1, 1'b1, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t2_still_valid", 256'(o_out_valid), 256'(1));
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_ready_after", 256'(o_in_ready),  256'(1));
    check("t2_valid_after", 256'(o_out_valid), 256'(0));

    // 3: ~50% gaps, same data, then random data with random gaps
    send_frame(1, 1'b1, 50, 1'b0);
    drain();
    for (int f = 0; f < 3; f++) begin
      send_frame(0, 1'b1, $urandom_range(0, 60), 1'b1);
      drain();
    end

    // 4: early last on element 7
    for (int k = 0; k < 7; k++) send(ELEM_W'(100 + k), k == 6, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_err",   256'(o_frame_err), 256'(1));
    check("t4_valid", 256'(o_out_valid), 256'(0));
    send_frame(1, 1'b1, 0, 1'b0);
    drain();

    // 5: complete frame with no in_last
    do_clear();
    send_frame(50, 1'b0, 20, 1'b0);
    drain();
    check("t5_err", 256'(o_frame_err), 256'(1));

    // 6a: clear together with element 12
    for (int k = 0; k < 11; k++) send(ELEM_W'(200 + k), 1'b0, 0);
    i_in_data = 8'hEE; i_in_last = 1'b0; i_in_valid = 1'b1;
    do_clear();
    send_frame(7, 1'b1, 0, 1'b0);
    drain();

    // 6b: reset while holding a matrix
    i_out_ready = 1'b0;
    send_frame(0, 1'b1, 0, 1'b1);
    @(posedge clk); #2;
    i_reset = 1'b1;
    exp_mat_q.delete();
    exp_err_q.delete();
    frame_q.delete();
    m_err = 1'b0;
    #1;
    check("t6_rst_valid",  256'(o_out_valid),  256'(0));
    check("t6_rst_matrix", 256'(o_matrix),     256'(0));
    check("t6_rst_count",  256'(o_elem_count), 256'(0));
    check("t6_rst_ready",  256'(o_in_ready),   256'(1));
    @(posedge clk); #3;
    i_reset = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 1'b1, 30, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 256'(exp_mat_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
